// File: rtl/alu_seq_if.sv
// Operation bus between the sequencing controller (master) and alu_seq (slave).
// Carries the request, operands, result, flags and the busy/done handshake.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] Input1;
  logic [WIDTH-1:0] Input2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;

  modport master (
    output start, opcode, Input1, Input2,
    input  busy, done, out, zero_flag, carry_flag, overflow_flag
  );

  modport slave (
    input  start, opcode, Input1, Input2,
    output busy, done, out, zero_flag, carry_flag, overflow_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/pass ops plus a WIDTH-cycle
// shift-add multiply sequenced by a two-state FSM.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_ONE   = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_PASSA = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [PW-1:0]    r_mcand,  w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [PW-1:0]    r_prod,   w_prod_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0] r_out,    w_out_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             r_carry,  w_carry_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;

  logic [WIDTH-1:0] w_opb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_carry;
  logic             w_alu_ovf;

  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_prod_sum;
  logic             w_mul_last;

  // Single-cycle datapath; inc/dec reuse the adder/subtractor with B forced to 1.
  always_comb begin
    w_opb       = ((bus.opcode == OP_INC) || (bus.opcode == OP_DEC)) ?
                  WIDTH'(1) : bus.Input2;
    w_sum       = {1'b0, bus.Input1} + {1'b0, w_opb};
    w_diff      = {1'b0, bus.Input1} - {1'b0, w_opb};
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_ovf   = 1'b0;
    case (bus.opcode)
      OP_ONE:   w_alu_res = WIDTH'(1);
      OP_INC, OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        w_alu_ovf   = (bus.Input1[MSB] == w_opb[MSB]) &&
                      (w_alu_res[MSB] != bus.Input1[MSB]);
      end
      OP_DEC, OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
        w_alu_ovf   = (bus.Input1[MSB] != w_opb[MSB]) &&
                      (w_alu_res[MSB] != bus.Input1[MSB]);
      end
      OP_PASSA: w_alu_res = bus.Input1;
      OP_PASSB: w_alu_res = bus.Input2;
      default:  w_alu_res = '0;
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : '0;
    w_prod_sum = r_prod + w_addend;
    w_mul_last = (r_cnt == CW'(WIDTH - 1));
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_prod_nxt   = r_prod;
    w_cnt_nxt    = r_cnt;
    w_out_nxt    = r_out;
    w_zero_nxt   = r_zero;
    w_carry_nxt  = r_carry;
    w_ovf_nxt    = r_ovf;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.opcode == OP_MUL) begin
            w_mcand_nxt  = PW'(bus.Input1);
            w_mplier_nxt = bus.Input2;
            w_prod_nxt   = '0;
            w_cnt_nxt    = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = ST_MUL;
          end else begin
            w_out_nxt   = w_alu_res;
            w_zero_nxt  = (w_alu_res == '0);
            w_carry_nxt = w_alu_carry;
            w_ovf_nxt   = w_alu_ovf;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        w_prod_nxt   = w_prod_sum;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CW'(1);
        if (w_mul_last) begin
          w_out_nxt   = w_prod_sum[WIDTH-1:0];
          w_zero_nxt  = (w_prod_sum[WIDTH-1:0] == '0);
          w_carry_nxt = |w_prod_sum[PW-1:WIDTH];
          w_ovf_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_prod   <= w_prod_nxt;
      r_cnt    <= w_cnt_nxt;
      r_out    <= w_out_nxt;
      r_zero   <= w_zero_nxt;
      r_carry  <= w_carry_nxt;
      r_ovf    <= w_ovf_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.out           = r_out;
  assign bus.zero_flag     = r_zero;
  assign bus.carry_flag    = r_carry;
  assign bus.overflow_flag = r_ovf;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an integer-arithmetic
// reference model of the opcode, flag and handshake rules.
module tb_alu_seq;

  localparam int unsigned W = 8;
  localparam int M = 1 << W;

  logic clk;
  logic rst;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] e_out;
  logic         e_z;
  logic         e_c;
  logic         e_v;

  int fib_prev;
  int fib_cur;
  int fib_sum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  // Expected result and flags from plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi, r, s;
    ai = int'(a);
    bi = int'(b);
    r = 0;
    s = 0;
    e_c = 1'b0;
    case (op)
      3'd0: begin r = ai * bi; e_c = (r >= M); end
      3'd1: r = 1;
      3'd2: begin r = ai + 1;  e_c = (r >= M);  s = sgn(ai) + 1; end
      3'd3: begin r = ai - 1;  e_c = (ai < 1);  s = sgn(ai) - 1; end
      3'd4: r = ai;
      3'd5: begin r = ai - bi; e_c = (ai < bi); s = sgn(ai) - sgn(bi); end
      3'd6: begin r = ai + bi; e_c = (r >= M);  s = sgn(ai) + sgn(bi); end
      default: r = bi;
    endcase
    e_v   = (s > M / 2 - 1) || (s < -(M / 2));
    e_out = W'(((r % M) + M) % M);
    e_z   = (e_out == '0);
  endfunction

  task automatic chk_res(input string tag);
    chk({tag, ".out"},  32'(bus.out),           32'(e_out));
    chk({tag, ".zero"}, 32'(bus.zero_flag),     32'(e_z));
    chk({tag, ".carry"},32'(bus.carry_flag),    32'(e_c));
    chk({tag, ".ovf"},  32'(bus.overflow_flag), 32'(e_v));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".out"},  32'(bus.out),           0);
    chk({tag, ".zero"}, 32'(bus.zero_flag),     0);
    chk({tag, ".carry"},32'(bus.carry_flag),    0);
    chk({tag, ".ovf"},  32'(bus.overflow_flag), 0);
    chk({tag, ".busy"}, 32'(bus.busy),          0);
    chk({tag, ".done"}, 32'(bus.done),          0);
  endtask

  // One single-cycle op; start is left high so consecutive calls run back-to-back.
  task automatic op1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.Input1 = a;
    bus.Input2 = b;
    @(posedge clk);
    #1;
    ref_op(op, a, b);
    chk($sformatf("op%0d.done", op), 32'(bus.done), 1);
    chk($sformatf("op%0d.busy", op), 32'(bus.busy), 0);
    chk_res($sformatf("op%0d", op));
  endtask

  task automatic dir(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input int exp_out);
    op1(op, a, b);
    chk({tag, ".lit"}, 32'(bus.out), 32'(exp_out));
  endtask

  // Idle cycle with scrambled inputs: done must drop and results must hold.
  task automatic idle();
    @(negedge clk);
    bus.start  = 1'b0;
    bus.opcode = 3'($urandom);
    bus.Input1 = W'($urandom);
    bus.Input2 = W'($urandom);
    @(posedge clk);
    #1;
    chk("idle.done", 32'(bus.done), 0);
    chk("idle.busy", 32'(bus.busy), 0);
    chk_res("idle");
  endtask

  // Multiply with cycle-exact busy/done checks; inject raises an ADD start while busy.
  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 3'b000;
    bus.Input1 = a;
    bus.Input2 = b;
    @(posedge clk);
    #1;
    chk("mul.busy0", 32'(bus.busy), 1);
    chk("mul.done0", 32'(bus.done), 0);
    for (int k = 1; k <= int'(W); k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start  = 1'b0;
        bus.opcode = 3'($urandom);
        bus.Input1 = W'($urandom);
        bus.Input2 = W'($urandom);
      end
      if (inject && k == 3) begin
        bus.start  = 1'b1;
        bus.opcode = 3'b110;
      end
      if (inject && k == 4) bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (k < int'(W)) begin
        chk("mul.busy", 32'(bus.busy), 1);
        chk("mul.done", 32'(bus.done), 0);
        chk_res("mul.hold");
      end else begin
        ref_op(3'b000, a, b);
        chk("mul.donepulse", 32'(bus.done), 1);
        chk("mul.busyfall",  32'(bus.busy), 0);
        chk_res("mul");
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.opcode = 3'b000;
    bus.Input1 = '0;
    bus.Input2 = '0;
    e_out = '0; e_z = 1'b0; e_c = 1'b0; e_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    dir("one", 3'b001, 8'd0, 8'd0, 1);
    idle();

    dir("add200_100", 3'b110, 8'd200, 8'd100, 44);
    dir("add127_1",   3'b110, 8'd127, 8'd1,   128);
    dir("sub5_7",     3'b101, 8'd5,   8'd7,   254);
    dir("sub128_1",   3'b101, 8'd128, 8'd1,   127);
    dir("inc255",     3'b010, 8'd255, 8'd9,   0);
    dir("dec0",       3'b011, 8'd0,   8'd3,   255);
    dir("dec128",     3'b011, 8'd128, 8'd0,   127);
    dir("passa",      3'b100, 8'd0,   8'd77,  0);
    dir("passb",      3'b111, 8'd12,  8'd77,  77);
    idle();

    mul(8'd15, 8'd17, 1'b0);
    chk("mul15_17.lit", 32'(bus.out), 255);
    idle();
    mul(8'd16, 8'd16, 1'b0);
    chk("mul16_16.lit", 32'(bus.out), 0);
    mul(8'd200, 8'd3, 1'b1);
    chk("mulbusy.lit", 32'(bus.out), 88);
    dir("after_mul", 3'b110, 8'd10, 8'd20, 30);
    idle();

    // Asynchronous reset mid-run, between edges.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    e_out = '0; e_z = 1'b0; e_c = 1'b0; e_v = 1'b0;
    dir("one_after_rst", 3'b001, 8'd0, 8'd0, 1);
    idle();

    // Reset four cycles into a multiply: no done, result cleared.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 3'b000;
    bus.Input1 = 8'd13;
    bus.Input2 = 8'd11;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mul_rst");
    @(negedge clk);
    rst = 1'b0;
    e_out = '0; e_z = 1'b0; e_c = 1'b0; e_v = 1'b0;
    repeat (3) idle();

    // Fibonacci chain fed from the model's previous result.
    dir("fib0", 3'b001, 8'd0, 8'd0, 1);
    fib_prev = 0;
    fib_cur  = 1;
    do begin
      fib_sum = fib_prev + fib_cur;
      dir("fib", 3'b110, W'(fib_prev), W'(fib_cur), fib_sum % M);
      chk("fib.carry", 32'(bus.carry_flag), 32'(fib_sum >= M));
      fib_prev = fib_cur;
      fib_cur  = fib_sum;
    end while (fib_sum < M);
    chk("fib_end.lit", 32'(bus.out), 121);
    idle();

    repeat (150) begin
      logic [2:0]   r_op;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      r_op = 3'($urandom_range(0, 7));
      r_a  = W'($urandom);
      r_b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) r_a = '0;
      if ($urandom_range(0, 7) == 0) r_b = {W{1'b1}};
      if (r_op == 3'b000) mul(r_a, r_b, $urandom_range(0, 3) == 0);
      else                op1(r_op, r_a, r_b);
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
